// File: rtl/mac_ctrl_pkg.sv
// aegnn: shared datapath types and the mac_ctrl FSM state encoding
package aegnn;
  typedef logic [7:0] f_t;
  typedef logic signed [7:0] w_t;
  typedef logic signed [31:0] accum_t;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} mac_state_e;
endpackage

// File: rtl/mac_ctrl_if.sv
// mac_ctrl_if: job, memory-read, MAC and result signals of mac_ctrl
interface mac_ctrl_if #(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 10
);
  import aegnn::*;
  logic              job_valid;
  logic              job_ready;
  logic [LEN_W-1:0]  job_len;
  logic [ADDR_W-1:0] job_f_base;
  logic [ADDR_W-1:0] job_w_base;
  logic              rd_en;
  logic [ADDR_W-1:0] f_addr;
  logic [ADDR_W-1:0] w_addr;
  f_t                f_rdata;
  w_t                w_rdata;
  f_t                mac_feature;
  w_t                mac_weight;
  logic              mac_valid;
  logic              mac_clear;
  accum_t            mac_accum;
  logic              res_valid;
  logic              res_ready;
  accum_t            res_data;
  modport slave (
    input  job_valid, job_len, job_f_base, job_w_base, f_rdata, w_rdata, mac_accum, res_ready,
    output job_ready, rd_en, f_addr, w_addr, mac_feature, mac_weight, mac_valid, mac_clear,
           res_valid, res_data
  );
  modport master (
    output job_valid, job_len, job_f_base, job_w_base, f_rdata, w_rdata, mac_accum, res_ready,
    input  job_ready, rd_en, f_addr, w_addr, mac_feature, mac_weight, mac_valid, mac_clear,
           res_valid, res_data
  );
endinterface

// File: rtl/mac_ctrl.sv
// mac_ctrl: sequences feature/weight reads into an external MAC and returns the dot product
module mac_ctrl #(
  parameter int LATENCY = 4,
  parameter int LEN_W   = 8,
  parameter int ADDR_W  = 10
) (
  input logic      clk,
  input logic      rstn,
  mac_ctrl_if.slave bus
);
  import aegnn::*;
  localparam int DW = $clog2(LATENCY + 2);
  mac_state_e        state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DW-1:0]     dly_q, dly_d;
  logic [ADDR_W-1:0] f_addr_q, f_addr_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic              mac_valid_q, mac_valid_d;
  logic              first_q, first_d;
  accum_t            res_q, res_d;
  // state and datapath registers, cleared asynchronously so a reset drops any job in flight
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      dly_q       <= '0;
      f_addr_q    <= '0;
      w_addr_q    <= '0;
      mac_valid_q <= 1'b0;
      first_q     <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dly_q       <= dly_d;
      f_addr_q    <= f_addr_d;
      w_addr_q    <= w_addr_d;
      mac_valid_q <= mac_valid_d;
      first_q     <= first_d;
      res_q       <= res_d;
    end
  end
  // next state: remaining-read count ends ISSUE, latency down-counter ends DRAIN
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dly_d       = dly_q;
    f_addr_d    = f_addr_q;
    w_addr_d    = w_addr_q;
    res_d       = res_q;
    mac_valid_d = state_q == ISSUE;
    first_d     = mac_valid_q ? 1'b0 : first_q;
    case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          rem_d    = bus.job_len;
          f_addr_d = bus.job_f_base;
          w_addr_d = bus.job_w_base;
          first_d  = 1'b1;
          res_d    = bus.job_len == '0 ? '0 : res_q;
          state_d  = bus.job_len == '0 ? OUT : ISSUE;
        end
      end
      ISSUE: begin
        f_addr_d = f_addr_q + 1'b1;
        w_addr_d = w_addr_q + 1'b1;
        rem_d    = rem_q - 1'b1;
        dly_d    = DW'(LATENCY);
        state_d  = rem_q == LEN_W'(1) ? DRAIN : ISSUE;
      end
      DRAIN: begin
        dly_d   = dly_q == '0 ? dly_q : dly_q - 1'b1;
        res_d   = dly_q == '0 ? bus.mac_accum : res_q;
        state_d = dly_q == '0 ? OUT : DRAIN;
      end
      OUT: state_d = bus.res_ready ? IDLE : OUT;
    endcase
  end
  assign bus.job_ready   = rstn && state_q == IDLE;
  assign bus.rd_en       = state_q == ISSUE;
  assign bus.f_addr      = f_addr_q;
  assign bus.w_addr      = w_addr_q;
  assign bus.mac_feature = bus.f_rdata;
  assign bus.mac_weight  = bus.w_rdata;
  assign bus.mac_valid   = mac_valid_q;
  assign bus.mac_clear   = mac_valid_q & first_q;
  assign bus.res_valid   = state_q == OUT;
  assign bus.res_data    = res_q;
endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: scoreboard bench for mac_ctrl with behavioural memories and MAC
module tb_mac_ctrl;
  import aegnn::*;
  localparam int LAT = 4;
  typedef struct {longint data; int cyc; int len;} exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t sb[$];
  int aq_f[$];
  int aq_w[$];
  f_t fmem [1024];
  w_t wmem [1024];
  accum_t pipe [LAT];
  accum_t prod;
  mac_ctrl_if #(.LEN_W(8), .ADDR_W(10)) bus ();
  mac_ctrl #(.LATENCY(LAT), .LEN_W(8), .ADDR_W(10)) dut (.clk(clk), .rstn(rstn), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.rd_en) begin
    bus.f_rdata <= fmem[bus.f_addr];
    bus.w_rdata <= wmem[bus.w_addr];
  end
  assign prod = accum_t'(bus.mac_feature) * accum_t'(bus.mac_weight);
  always @(posedge clk) begin
    if (bus.mac_valid) pipe[0] <= bus.mac_clear ? prod : pipe[0] + prod;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mac_accum = pipe[LAT-1];
  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask
  // monitor: addresses, mac_clear placement, result timing/value/term count
  initial begin
    exp_t cur;
    bit seen = 0;
    bit exp_first = 0;
    int mv_cnt = 0;
    int fa, wa;
    forever begin
      @(negedge clk);
      if (!rstn) seen = 0;
      else begin
        if (bus.job_valid && bus.job_ready) begin exp_first = 1; mv_cnt = 0; end
        if (bus.rd_en) begin
          if (aq_f.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rd_extra act=%0d exp=none", bus.f_addr);
          end else begin
            fa = aq_f.pop_front(); wa = aq_w.pop_front();
            chk("f_addr", bus.f_addr, fa);
            chk("w_addr", bus.w_addr, wa);
          end
        end
        if (bus.mac_valid) begin
          chk("mac_clear", bus.mac_clear, exp_first);
          exp_first = 0;
          mv_cnt++;
        end else if (bus.mac_clear) chk("mac_clear_idle", bus.mac_clear, 0);
        if (bus.res_valid) begin
          if (!seen) begin
            seen = 1;
            if (sb.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL res_unexpected act=%0d exp=none", bus.res_data);
              cur = '{longint'(bus.res_data), cyc, mv_cnt};
            end else begin
              cur = sb.pop_front();
              chk("res_data", bus.res_data, cur.data);
              chk("res_cycle", cyc, cur.cyc);
              chk("mac_valid_count", mv_cnt, cur.len);
            end
          end
          if (bus.res_ready) begin
            chk("res_hold", bus.res_data, cur.data);
            seen = 0;
          end
        end
      end
    end
  end
  task automatic send(input int len, input int fb, input int wb, input longint exp);
    int n = 0;
    @(posedge clk); #1;
    bus.job_valid  = 1'b1;
    bus.job_len    = 8'(len);
    bus.job_f_base = 10'(fb);
    bus.job_w_base = 10'(wb);
    while (!bus.job_ready && n < 3000) begin @(posedge clk); #1; n++; end
    chk("job_accept", bus.job_ready, 1);
    if (bus.job_ready) begin
      sb.push_back('{exp, cyc + (len == 0 ? 1 : len + 2 + LAT), len});
      for (int i = 0; i < len; i++) begin
        aq_f.push_back((fb + i) % 1024);
        aq_w.push_back((wb + i) % 1024);
      end
    end
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
  endtask
  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk("sb_drain", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic hold5();
    int n = 0;
    while (!bus.res_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("hold_wait", bus.res_valid, 1);
    repeat (5) begin
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_job_ready", bus.job_ready, 0);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b1;
  endtask
  task automatic chk_reset();
    chk("rst_job_ready", bus.job_ready, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_mac_valid", bus.mac_valid, 0);
    chk("rst_mac_clear", bus.mac_clear, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_f_addr", bus.f_addr, 0);
    chk("rst_w_addr", bus.w_addr, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.job_valid = 0; bus.job_len = 0; bus.job_f_base = 0; bus.job_w_base = 0; bus.res_ready = 0;
    for (int i = 0; i < 1024; i++) begin fmem[i] = 0; wmem[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rstn = 1'b1;
    #1;
    chk("post_rst_job_ready", bus.job_ready, 1);
    bus.res_ready = 1'b1;
    fmem[0] = 2; fmem[1] = 3; fmem[2] = 4;
    wmem[0] = 1; wmem[1] = -1; wmem[2] = 2;
    send(3, 0, 0, 7);
    wait_empty();
    send(0, 5, 5, 0);
    wait_empty();
    fmem[1022] = 1; fmem[1023] = 2; fmem[0] = 3; fmem[1] = 4;
    wmem[100] = 5; wmem[101] = 6; wmem[102] = 7; wmem[103] = 8;
    send(4, 1022, 100, 70);
    wait_empty();
    fmem[200] = 10; fmem[201] = 20; wmem[300] = 3; wmem[301] = -2;
    fmem[210] = 7; wmem[310] = -9;
    bus.res_ready = 1'b0;
    fork
      begin send(2, 200, 300, -10); send(1, 210, 310, -63); end
      hold5();
    join
    wait_empty();
    send(10, 400, 400, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rstn = 1'b0;
    #1;
    chk_reset();
    sb.delete(); aq_f.delete(); aq_w.delete();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    fmem[500] = 255; fmem[501] = 128; wmem[600] = -128; wmem[601] = 127;
    send(2, 500, 600, -16384);
    wait_empty();
    for (int i = 0; i < 255; i++) begin fmem[i] = 255; wmem[512 + i] = -128; end
    send(255, 0, 512, -8323200);
    wait_empty();
    chk("addr_q_empty", aq_f.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning the MAC pipeline depth (cycles from mac_valid term to its accumulated value on mac_accum).
REQ-002 SHALL have parameter LEN_W, default 8, meaning the job length counter width.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning the feature/weight memory address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  asynchronous, active-low reset.
REQ-006 job_valid / job_ready  in / out  1 / 1  job request handshake.
REQ-007 job_len  in  LEN_W  number of feature*weight terms; 0 legal.
REQ-008 job_f_base, job_w_base  in  ADDR_W  first feature / weight address.
REQ-009 rd_en  out  1  memory read strobe; data returns one cycle later.
REQ-010 f_addr, w_addr  out  ADDR_W  read addresses.
REQ-011 f_rdata, w_rdata  in  f_t, w_t  memory read data.
REQ-012 mac_feature, mac_weight, mac_valid, mac_clear  out  f_t, w_t, 1, 1  MAC operands, term strobe, accumulator-load strobe.
REQ-013 mac_accum  in  accum_t  MAC accumulated output.
REQ-014 res_valid / res_ready  out / in  1 / 1  result handshake; res_data  out  accum_t  dot-product result.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, DRAIN, OUT.
REQ-016 IDLE: job_ready=1; on job_valid&job_ready latch job_len, bases; len>0 -> ISSUE; len==0 -> OUT with res_data=0.
REQ-017 ISSUE: rd_en=1 every cycle, addresses start at bases and increment by 1, wrapping modulo 2^ADDR_W; after job_len reads -> DRAIN.
REQ-018 mac_valid SHALL equal rd_en delayed one cycle; mac_feature/mac_weight SHALL be f_rdata/w_rdata passed through combinationally.
REQ-019 mac_clear SHALL be high only with the first mac_valid of a job (MAC loads, not adds); low otherwise.
REQ-020 With accept at cycle 0: rd_en cycles 1..N, mac_valid cycles 2..N+1, res_data captured from mac_accum at cycle N+1+LATENCY, res_valid high from cycle N+2+LATENCY.
REQ-021 DRAIN SHALL count LATENCY cycles after last mac_valid with a down-counter, then capture and -> OUT.
REQ-022 OUT: res_valid and res_data held stable until res_ready; on handshake -> IDLE; job_ready not asserted in the same cycle (no bypass).
REQ-023 No saturation or rounding; accum_t width and overflow are the MAC's concern.
REQ-024 job_valid while not IDLE SHALL be ignored (job_ready=0).
REQ-025 job_len = 2^LEN_W-1 SHALL complete correctly without counter overflow.

Reset
REQ-026 rstn low SHALL asynchronously force IDLE, job_ready=0 during reset then 1, rd_en=0, mac_valid=0, mac_clear=0, res_valid=0, res_data=0, addresses=0, counters=0.
REQ-027 Reset mid-job SHALL discard the job; no res_valid afterwards for it.

Structure
REQ-028 f_t, w_t, accum_t SHALL come from package aegnn; FSM state enum SHALL be added to aegnn.
REQ-029 mac_ctrl SHALL NOT instantiate MAC; the parent connects mac_ctrl to one MAC instance with matching LATENCY.
REQ-030 One sub-module is natural: none required; a single file suffices.

Verification
REQ-031 LATENCY=4, len=3, features {2,3,4}, weights {1,-1,2}: res_data=7, res_valid at cycle 9 after accept.
REQ-032 len=0: res_valid at cycle 1, res_data=0, no rd_en pulse.
REQ-033 f_base=1022, ADDR_W=10, len=4: f_addr sequence 1022,1023,0,1.
REQ-034 Two back-to-back jobs with res_ready held low 5 cycles: result stable, second job_ready only after handshake, second result independent (mac_clear on its first term).
REQ-035 rstn asserted during ISSUE of len=10 job: all outputs to reset values immediately; next job len=2 {255x-128,128x127} gives -16384.
REQ-036 len=255, all features 255, weights -128: res_data=-8323200, no missed/extra mac_valid (count 255).
